// File: rtl/bcd_operand_loader.sv
// Operand-entry stage: captures BCD digit A, then digit B plus carry-in, one per debounced key press.
// Define BCD_LOADER_DEBOUNCE_EN to enable the counter-based debouncer; otherwise the synced key is used directly.
module bcd_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] digit_in,
  input  logic       cin_in,
  input  logic       load_n,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       ci,
  output logic       valid,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_SHOW = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  logic       sync1_r, sync2_r;
  logic       deb_s, deb_prev_r;
  logic       press_s, digit_ok_s;

  state_t     state_r, state_nxt_s;
  logic [3:0] a_r, a_nxt_s;
  logic [3:0] b_r, b_nxt_s;
  logic       ci_r, ci_nxt_s;
  logic       valid_r, valid_nxt_s;
  logic       err_r, err_nxt_s;

  // Two-flop synchronizer for the asynchronous pushbutton; idles released (high).
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= load_n;
      sync2_r <= sync1_r;
    end
  end

`ifdef BCD_LOADER_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             deb_r;

  // Debouncer: a changed level must persist DEBOUNCE_CYCLES cycles before it is accepted.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_r <= '0;
      deb_r <= 1'b1;
    end else if (sync2_r == deb_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      deb_r <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign deb_s = deb_r;
`else
  assign deb_s = sync2_r;
`endif

  // Remember previous debounced level so a held key yields a single press.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      deb_prev_r <= 1'b1;
    end else begin
      deb_prev_r <= deb_s;
    end
  end

  assign press_s    = deb_prev_r & ~deb_s;
  assign digit_ok_s = is_bcd(digit_in);

  // Next-state and capture logic; registers hold unless a press arrives.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    ci_nxt_s    = ci_r;
    valid_nxt_s = valid_r;
    err_nxt_s   = err_r;
    case (state_r)
      S_A: begin
        if (press_s && digit_ok_s) begin
          a_nxt_s     = digit_in;
          err_nxt_s   = 1'b0;
          state_nxt_s = S_B;
        end else if (press_s) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end
      S_B: begin
        if (press_s && digit_ok_s) begin
          b_nxt_s     = digit_in;
          ci_nxt_s    = cin_in;
          err_nxt_s   = 1'b0;
          valid_nxt_s = 1'b1;
          state_nxt_s = S_SHOW;
        end else if (press_s) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end
      S_SHOW: begin
        // A valid digit here is the A operand of the next pair.
        if (press_s && digit_ok_s) begin
          valid_nxt_s = 1'b0;
          a_nxt_s     = digit_in;
          err_nxt_s   = 1'b0;
          state_nxt_s = S_B;
        end else if (press_s) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = S_A;
      end
    endcase
  end

  // Operand and FSM registers; reset overrides any press on the same edge.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= S_A;
      a_r     <= 4'd0;
      b_r     <= 4'd0;
      ci_r    <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      ci_r    <= ci_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign a     = a_r;
  assign b     = b_r;
  assign ci    = ci_r;
  assign valid = valid_r;
  assign err   = err_r;
  assign state = state_r;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Scoreboard bench for bcd_operand_loader: stimulus queues expected outputs, a monitor pops and compares.
module tb_bcd_operand_loader;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       cin_in = 1'b0;
  logic       load_n = 1'b1;
  logic [3:0] a, b;
  logic       ci, valid, err;
  logic [1:0] state;

  bcd_operand_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .Clock(Clock), .Resetn(Resetn), .digit_in(digit_in), .cin_in(cin_in), .load_n(load_n),
    .a(a), .b(b), .ci(ci), .valid(valid), .err(err), .state(state)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic       valid;
    logic       err;
    logic [1:0] state;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: whenever a check is requested, pop the expected tuple and compare against the DUT.
  initial begin
    forever begin
      exp_t e;
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({a, b, ci, valid, err, state} !== {e.a, e.b, e.ci, e.valid, e.err, e.state}) begin
          miscompares++;
          $display("FAIL %s: got a=%0d b=%0d ci=%0b valid=%0b err=%0b state=%02b, want a=%0d b=%0d ci=%0b valid=%0b err=%0b state=%02b",
                   e.name, a, b, ci, valid, err, state, e.a, e.b, e.ci, e.valid, e.err, e.state);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [3:0] ea, input logic [3:0] eb,
                            input logic eci, input logic ev, input logic ee, input logic [1:0] es);
    exp_t e;
    e.a = ea; e.b = eb; e.ci = eci; e.valid = ev; e.err = ee; e.state = es; e.name = name;
    exp_q.push_back(e);
    -> chk_ev;
    @(negedge Clock);
  endtask

  task automatic press(input logic [3:0] d, input logic c);
    @(negedge Clock);
    digit_in = d;
    cin_in   = c;
    load_n   = 1'b0;
    repeat (12) @(negedge Clock);
    load_n = 1'b1;
    repeat (12) @(negedge Clock);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    expect_out("reset_state", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);

    press(4'd7, 1'b0);
    expect_out("capture_a7", 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01);
    press(4'd8, 1'b1);
    expect_out("capture_b8_ci1", 4'd7, 4'd8, 1'b1, 1'b1, 1'b0, 2'b10);

    digit_in = 4'd2; cin_in = 1'b0;
    repeat (20) @(negedge Clock);
    expect_out("switch_no_press", 4'd7, 4'd8, 1'b1, 1'b1, 1'b0, 2'b10);

    press(4'd14, 1'b0);
    expect_out("show_reject_14", 4'd7, 4'd8, 1'b1, 1'b1, 1'b1, 2'b10);
    press(4'd4, 1'b0);
    expect_out("show_next_a4", 4'd4, 4'd8, 1'b1, 1'b0, 1'b0, 2'b01);
    press(4'd10, 1'b0);
    expect_out("b_reject_10", 4'd4, 4'd8, 1'b1, 1'b0, 1'b1, 2'b01);
    press(4'd0, 1'b0);
    expect_out("capture_b0_ci0", 4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 2'b10);

    do_reset();
    expect_out("reset_from_show", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);

    press(4'd12, 1'b0);
    expect_out("a_reject_12", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00);
    press(4'd3, 1'b0);
    expect_out("a_accept_3", 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01);
    press(4'd9, 1'b1);
    expect_out("b_boundary_9", 4'd3, 4'd9, 1'b1, 1'b1, 1'b0, 2'b10);

    // Long hold must capture exactly once.
    do_reset();
    @(negedge Clock);
    digit_in = 4'd6; cin_in = 1'b1;
    load_n = 1'b0;
    repeat (100) @(negedge Clock);
    expect_out("hold_low_once", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01);
    load_n = 1'b1;
    repeat (20) @(negedge Clock);
    expect_out("hold_release", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01);

    // Two-cycle glitch: filtered by the debouncer, seen as a press without it.
    @(negedge Clock);
    digit_in = 4'd9; cin_in = 1'b1;
    load_n = 1'b0;
    repeat (2) @(negedge Clock);
    load_n = 1'b1;
    repeat (20) @(negedge Clock);
`ifdef BCD_LOADER_DEBOUNCE_EN
    expect_out("glitch_filtered", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01);
`else
    expect_out("glitch_captured", 4'd6, 4'd9, 1'b1, 1'b1, 1'b0, 2'b10);
`endif

    // Reset on the very edge that would capture B.
    do_reset();
    press(4'd5, 1'b0);
    expect_out("a5_before_clash", 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01);
    @(negedge Clock);
    digit_in = 4'd7; cin_in = 1'b1;
    load_n = 1'b0;
`ifdef BCD_LOADER_DEBOUNCE_EN
    repeat (6) @(negedge Clock);
`else
    repeat (2) @(negedge Clock);
`endif
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    load_n = 1'b1;
    expect_out("reset_beats_press", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (20) @(negedge Clock);
    expect_out("no_late_capture", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);

    @(negedge Clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
